// File: rtl/inst_seq_ctrl.sv
// Multi-cycle instruction sequencer: fetch handshake, decode, LSU wait, write-back and halt.
// Optional performance counters are built only when INST_SEQ_CTRL_PERF_EN is defined.
module inst_seq_ctrl #(
  parameter int unsigned TO_W           = 8,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        if_req_valid,
  input  logic        if_req_ready,
  input  logic        if_rsp_valid,
  output logic        inst_we,
  input  logic        dec_load,
  input  logic        dec_store,
  input  logic        dec_jump,
  input  logic        dec_ebreak,
  input  logic [4:0]  dec_rd,
  output logic        lsu_req_valid,
  input  logic        lsu_req_ready,
  input  logic        lsu_rsp_valid,
  output logic        rf_we,
  output logic        pc_we,
  output logic        pc_sel,
  output logic        halt,
  output logic        timeout,
  output logic [3:0]  state,
  output logic [63:0] perf_cycle,
  output logic [63:0] perf_instret
);

  localparam int unsigned   CNT_W    = TO_W + 1;
  localparam logic [TO_W:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam bit            TO_EN    = (TIMEOUT_CYCLES != 0);

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_FETCH_REQ  = 4'd1,
    S_FETCH_WAIT = 4'd2,
    S_DECODE     = 4'd3,
    S_EXEC       = 4'd4,
    S_MEM_REQ    = 4'd5,
    S_MEM_WAIT   = 4'd6,
    S_WB         = 4'd7,
    S_HALT       = 4'd8
  } state_e;

  state_e            state_q, state_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              timeout_q, timeout_d;
  logic              in_wait;
  logic              hs_done;
  logic [TO_W:0]     to_cnt_inc;

  assign to_cnt_inc = {1'b0, to_cnt_q} + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    timeout_d     = timeout_q;
    to_cnt_d      = '0;
    in_wait       = 1'b0;
    hs_done       = 1'b0;
    if_req_valid  = 1'b0;
    inst_we       = 1'b0;
    lsu_req_valid = 1'b0;
    rf_we         = 1'b0;
    pc_we         = 1'b0;
    pc_sel        = 1'b0;
    halt          = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH_REQ;
      end
      S_FETCH_REQ: begin
        if_req_valid = 1'b1;
        in_wait      = 1'b1;
        hs_done      = if_req_ready;
        if (if_req_ready) state_d = S_FETCH_WAIT;
      end
      S_FETCH_WAIT: begin
        in_wait = 1'b1;
        hs_done = if_rsp_valid;
        inst_we = if_rsp_valid;
        if (if_rsp_valid) state_d = S_DECODE;
      end
      S_DECODE: begin
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (dec_ebreak)                  state_d = S_HALT;
        else if (dec_load || dec_store)  state_d = S_MEM_REQ;
        else                             state_d = S_WB;
      end
      S_MEM_REQ: begin
        lsu_req_valid = 1'b1;
        in_wait       = 1'b1;
        hs_done       = lsu_req_ready;
        if (lsu_req_ready) state_d = S_MEM_WAIT;
      end
      S_MEM_WAIT: begin
        in_wait = 1'b1;
        hs_done = lsu_rsp_valid;
        if (lsu_rsp_valid) state_d = S_WB;
      end
      S_WB: begin
        pc_we   = 1'b1;
        pc_sel  = dec_jump;
        rf_we   = !dec_store && (dec_rd != 5'd0);
        state_d = S_FETCH_REQ;
      end
      S_HALT: begin
        halt = 1'b1;
      end
      default: begin
        state_d = S_HALT;
      end
    endcase

    // A stalled wait state fires when this cycle's count would reach the limit;
    // a handshake on the same cycle takes precedence.
    if (TO_EN && in_wait && !hs_done) begin
      if (to_cnt_inc == TO_LIMIT) begin
        state_d   = S_HALT;
        timeout_d = 1'b1;
      end else begin
        to_cnt_d = to_cnt_inc[TO_W-1:0];
      end
    end
  end

  assign state   = state_q;
  assign timeout = timeout_q;

`ifdef INST_SEQ_CTRL_PERF_EN
  logic [63:0] perf_cycle_q, perf_instret_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cycle_q   <= '0;
      perf_instret_q <= '0;
    end else begin
      if (state_q != S_IDLE && state_q != S_HALT) perf_cycle_q <= perf_cycle_q + 64'd1;
      if (state_q == S_WB) perf_instret_q <= perf_instret_q + 64'd1;
    end
  end

  assign perf_cycle   = perf_cycle_q;
  assign perf_instret = perf_instret_q;
`else
  assign perf_cycle   = '0;
  assign perf_instret = '0;
`endif

endmodule

// File: tb/tb_inst_seq_ctrl.sv
// Directed bench for inst_seq_ctrl: expands instruction-level scenarios into per-cycle
// expectations and checks every cycle, plus literal latency/count checks.
module tb_inst_seq_ctrl;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        if_req_ready = 1'b0, if_rsp_valid = 1'b0;
  logic        lsu_req_ready = 1'b0, lsu_rsp_valid = 1'b0;
  logic        dec_load = 1'b0, dec_store = 1'b0, dec_jump = 1'b0, dec_ebreak = 1'b0;
  logic [4:0]  dec_rd = 5'd0;
  logic        if_req_valid, inst_we, lsu_req_valid, rf_we, pc_we, pc_sel, halt, timeout;
  logic [3:0]  state;
  logic [63:0] perf_cycle, perf_instret;

  inst_seq_ctrl #(.TO_W(8), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .start(start),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_rsp_valid(if_rsp_valid),
    .inst_we(inst_we),
    .dec_load(dec_load), .dec_store(dec_store), .dec_jump(dec_jump), .dec_ebreak(dec_ebreak),
    .dec_rd(dec_rd),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_rsp_valid(lsu_rsp_valid),
    .rf_we(rf_we), .pc_we(pc_we), .pc_sel(pc_sel), .halt(halt), .timeout(timeout),
    .state(state), .perf_cycle(perf_cycle), .perf_instret(perf_instret)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       start, irr, irv, lrr, lrv;
    logic       ld, st, jmp, ebk;
    logic [4:0] rd;
    logic [3:0] e_state;
    logic       e_ifv, e_iwe, e_lsv, e_rfwe, e_pcwe, e_pcsel, e_halt, e_to;
  } vec_t;

  vec_t            q[$];
  vec_t            tmpl;
  bit              m_to;
  longint unsigned m_cyc, m_ret;
  int              n_chk, n_pass;
  string           run_name;
  int              first_iwe, first_pcwe, n_lsv, n_pcwe, n_rfwe, n_fw;
  logic            wb_pcsel;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s/%s: got 0x%0h expected 0x%0h at %0t", run_name, name, act, exp, $time);
  endtask

  // Expected values for a cycle spent in state s with no handshake.
  function automatic vec_t base(input logic [3:0] s);
    vec_t v = tmpl;
    v.e_state = s;
    v.e_halt  = (s == 4'd8);
    v.e_to    = m_to;
    v.e_ifv   = (s == 4'd1);
    v.e_lsv   = (s == 4'd5);
    return v;
  endfunction

  // A wait state held for 'delay' idle cycles before its handshake; TO idle cycles time out.
  task automatic wait_phase(input logic [3:0] s, input int delay, output bit to);
    vec_t v;
    int   n;
    to = (delay >= int'(TO));
    n  = to ? int'(TO) : delay;
    for (int i = 0; i < n; i++) q.push_back(base(s));
    if (!to) begin
      v = base(s);
      case (s)
        4'd1: v.irr = 1'b1;
        4'd2: begin v.irv = 1'b1; v.e_iwe = 1'b1; end
        4'd5: v.lrr = 1'b1;
        4'd6: v.lrv = 1'b1;
        default: ;
      endcase
      q.push_back(v);
    end
  endtask

  task automatic halt_phase(input int n, input bit by_to);
    vec_t v;
    m_to = m_to | by_to;
    for (int i = 0; i < n; i++) begin
      v = base(4'd8);
      v.start = i[0];
      q.push_back(v);
    end
  endtask

  task automatic add_start();
    vec_t v;
    tmpl = '0;
    v = base(4'd0);
    v.start = 1'b1;
    q.push_back(v);
  endtask

  task automatic add_idle(input int n);
    tmpl = '0;
    for (int i = 0; i < n; i++) q.push_back(base(4'd0));
  endtask

  task automatic add_instr(input bit ld, input bit st, input bit jmp, input bit ebk,
                           input logic [4:0] rd, input int fr, input int fv,
                           input int lr, input int lv);
    bit   to;
    vec_t v;
    tmpl = '0;
    tmpl.ld = ld; tmpl.st = st; tmpl.jmp = jmp; tmpl.ebk = ebk; tmpl.rd = rd;
    wait_phase(4'd1, fr, to);
    if (to) begin halt_phase(3, 1'b1); return; end
    wait_phase(4'd2, fv, to);
    if (to) begin halt_phase(3, 1'b1); return; end
    q.push_back(base(4'd3));
    q.push_back(base(4'd4));
    if (ebk) begin halt_phase(4, 1'b0); return; end
    if (ld || st) begin
      wait_phase(4'd5, lr, to);
      if (to) begin halt_phase(3, 1'b1); return; end
      wait_phase(4'd6, lv, to);
      if (to) begin halt_phase(3, 1'b1); return; end
    end
    v = base(4'd7);
    v.e_pcwe  = 1'b1;
    v.e_pcsel = jmp;
    v.e_rfwe  = !st && (rd != 5'd0);
    q.push_back(v);
  endtask

  task automatic drive_zero();
    start = 1'b0; if_req_ready = 1'b0; if_rsp_valid = 1'b0;
    lsu_req_ready = 1'b0; lsu_rsp_valid = 1'b0;
    dec_load = 1'b0; dec_store = 1'b0; dec_jump = 1'b0; dec_ebreak = 1'b0; dec_rd = 5'd0;
  endtask

  task automatic run_q(input string name);
    vec_t       v;
    logic [11:0] act, exp;
    run_name = name;
    first_iwe = -1; first_pcwe = -1; n_lsv = 0; n_pcwe = 0; n_rfwe = 0; n_fw = 0; wb_pcsel = 1'b0;
    for (int i = 0; i < q.size(); i++) begin
      v = q[i];
      @(negedge clk);
      start = v.start; if_req_ready = v.irr; if_rsp_valid = v.irv;
      lsu_req_ready = v.lrr; lsu_rsp_valid = v.lrv;
      dec_load = v.ld; dec_store = v.st; dec_jump = v.jmp; dec_ebreak = v.ebk; dec_rd = v.rd;
      #1;
      act = {state, if_req_valid, inst_we, lsu_req_valid, rf_we, pc_we, pc_sel, halt, timeout};
      exp = {v.e_state, v.e_ifv, v.e_iwe, v.e_lsv, v.e_rfwe, v.e_pcwe, v.e_pcsel, v.e_halt, v.e_to};
      chk($sformatf("outs[%0d]", i), 64'(act), 64'(exp));
`ifdef INST_SEQ_CTRL_PERF_EN
      chk($sformatf("perf_cycle[%0d]", i), perf_cycle, m_cyc);
      chk($sformatf("perf_instret[%0d]", i), perf_instret, m_ret);
`else
      chk($sformatf("perf_cycle[%0d]", i), perf_cycle, 64'd0);
      chk($sformatf("perf_instret[%0d]", i), perf_instret, 64'd0);
`endif
      if (inst_we && first_iwe < 0) first_iwe = i;
      if (pc_we && first_pcwe < 0) first_pcwe = i;
      if (pc_we) wb_pcsel = pc_sel;
      n_lsv  += int'(lsu_req_valid);
      n_pcwe += int'(pc_we);
      n_rfwe += int'(rf_we);
      n_fw   += int'(state == 4'd2);
      if (v.e_state != 4'd0 && v.e_state != 4'd8) m_cyc++;
      if (v.e_state == 4'd7) m_ret++;
    end
    q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive_zero();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_cyc = 0; m_ret = 0; m_to = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_pass = 0; m_cyc = 0; m_ret = 0; m_to = 1'b0;
    drive_zero();
    do_reset();

    add_idle(2);
    run_q("reset");

    add_start();
    add_instr(1'b0, 1'b0, 1'b0, 1'b0, 5'd5, 0, 0, 0, 0);
    run_q("alu");
    chk("alu_inst_we_cycle", 64'(first_iwe), 64'd2);
    chk("alu_wb_cycle", 64'(first_pcwe), 64'd5);
    chk("alu_rf_we_count", 64'(n_rfwe), 64'd1);

    add_instr(1'b0, 1'b1, 1'b0, 1'b0, 5'd9, 0, 0, 3, 0);
    run_q("store");
    chk("store_lsu_req_cycles", 64'(n_lsv), 64'd4);
    chk("store_rf_we_count", 64'(n_rfwe), 64'd0);
    chk("store_pc_we_count", 64'(n_pcwe), 64'd1);

    add_instr(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 0, 0, 0, 0);
    run_q("jal");
    chk("jal_rf_we_count", 64'(n_rfwe), 64'd0);
    chk("jal_pc_we_count", 64'(n_pcwe), 64'd1);
    chk("jal_pc_sel", 64'(wb_pcsel), 64'd1);

    add_instr(1'b1, 1'b0, 1'b0, 1'b0, 5'd7, 2, 1, 0, 2);
    run_q("load");
    chk("load_wb_cycle", 64'(first_pcwe), 64'd11);
    chk("load_rf_we_count", 64'(n_rfwe), 64'd1);

    add_instr(1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 0, 3, 0, 0);
    run_q("rsp_at_limit");
    chk("rsp_at_limit_inst_we_cycle", 64'(first_iwe), 64'd4);

    // Load parked in MEM_WAIT, then an asynchronous reset between clock edges.
    add_instr(1'b1, 1'b0, 1'b0, 1'b0, 5'd3, 0, 0, 0, 3);
    void'(q.pop_back());
    void'(q.pop_back());
    run_q("mid_reset");
    @(posedge clk);
    #2;
    chk("pre_reset_state", 64'(state), 64'd6);
    #1;
    rst = 1'b1;
    drive_zero();
    #1;
    chk("async_reset_outs",
        64'({state, if_req_valid, inst_we, lsu_req_valid, rf_we, pc_we, pc_sel, halt, timeout}),
        64'd0);
    chk("async_reset_perf_cycle", perf_cycle, 64'd0);
    chk("async_reset_perf_instret", perf_instret, 64'd0);
    m_cyc = 0; m_ret = 0; m_to = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    add_idle(3);
    run_q("post_reset_idle");

    add_start();
    add_instr(1'b1, 1'b0, 1'b0, 1'b1, 5'd4, 0, 0, 0, 0);
    run_q("ebreak");
    chk("ebreak_pc_we_count", 64'(n_pcwe), 64'd0);
    chk("ebreak_lsu_req_cycles", 64'(n_lsv), 64'd0);
    chk("ebreak_halt", 64'(halt), 64'd1);
    chk("ebreak_timeout", 64'(timeout), 64'd0);

    do_reset();
    add_start();
    add_instr(1'b0, 1'b0, 1'b0, 1'b0, 5'd2, 0, 99, 0, 0);
    run_q("fetch_timeout");
    chk("timeout_fetch_wait_cycles", 64'(n_fw), 64'd4);
    chk("timeout_flag", 64'(timeout), 64'd1);
    chk("timeout_halt", 64'(halt), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

endmodule
